// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT datapath (butterfly and controller).
//   FFT_DW / FFT_TW / FFT_MULT_LAT : default data width, twiddle width and
//                                    complex-multiplier register depth
//   round_const(frac_bits)         : half-LSB constant added before dropping
//                                    frac_bits fractional bits (round half-up)
//   sat(x, w) / sat_clip(x, w)     : clamp a signed value to a w-bit signed
//                                    range, and report whether a clamp happened
package fft_pkg;

    localparam int FFT_DW       = 16;
    localparam int FFT_TW       = 16;
    localparam int FFT_MULT_LAT = 2;

    function automatic logic signed [63:0] round_const(input int frac_bits);
        return 64'sd1 <<< (frac_bits - 1);
    endfunction

    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic sat_clip(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: pipelined complex multiply p = b * tw with round-half-up
// from Q1.(TW-1) back to integer scale, result kept at DW+1 bits.
//   clk, rst          : clock, synchronous active-high reset
//   tw_re, tw_im      : twiddle, signed Q1.(TW-1)
//   b_re, b_im        : operand, signed DW bits
//   p_re, p_im        : rounded product, signed DW+1 bits, MULT_LAT cycles later
// The first register stage holds the four partial products; the add/round
// is combinational after it and any remaining stages are a plain delay.
module cmplx_mult_pipe
    import fft_pkg::*;
#(
    parameter int DW       = FFT_DW,
    parameter int TW       = FFT_TW,
    parameter int MULT_LAT = FFT_MULT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW:0]   p_re,
    output logic signed [DW:0]   p_im
);

    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND = SW'(round_const(TW - 1));

    logic signed [PW-1:0] pp_rr_reg, pp_ii_reg, pp_ri_reg, pp_ir_reg;
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [DW:0]   p_re_next, p_im_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_rr_reg <= '0;
            pp_ii_reg <= '0;
            pp_ri_reg <= '0;
            pp_ir_reg <= '0;
        end else begin
            pp_rr_reg <= PW'(b_re) * PW'(tw_re);
            pp_ii_reg <= PW'(b_im) * PW'(tw_im);
            pp_ri_reg <= PW'(b_re) * PW'(tw_im);
            pp_ir_reg <= PW'(b_im) * PW'(tw_re);
        end
    end

    always_comb begin
        sum_re    = SW'(pp_rr_reg) - SW'(pp_ii_reg);
        sum_im    = SW'(pp_ri_reg) + SW'(pp_ir_reg);
        // Only DW+1 bits survive: with +1.0 excluded from the twiddle the
        // rounded magnitude never exceeds 2^DW - 1.
        p_re_next = (DW+1)'((sum_re + RND) >>> (TW - 1));
        p_im_next = (DW+1)'((sum_im + RND) >>> (TW - 1));
    end

    if (MULT_LAT == 1) begin : g_comb
        assign p_re = p_re_next;
        assign p_im = p_im_next;
    end else begin : g_regs
        logic signed [DW:0] re_sr_reg [MULT_LAT-1];
        logic signed [DW:0] im_sr_reg [MULT_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < MULT_LAT - 1; i++) begin
                    re_sr_reg[i] <= '0;
                    im_sr_reg[i] <= '0;
                end
            end else begin
                re_sr_reg[0] <= p_re_next;
                im_sr_reg[0] <= p_im_next;
                for (int i = 1; i < MULT_LAT - 1; i++) begin
                    re_sr_reg[i] <= re_sr_reg[i-1];
                    im_sr_reg[i] <= im_sr_reg[i-1];
                end
            end
        end

        assign p_re = re_sr_reg[MULT_LAT-2];
        assign p_im = im_sr_reg[MULT_LAT-2];
    end

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: pipelined radix-2 DIT butterfly.
//   outa = a - b*tw, outb = a + b*tw, tw being the negated twiddle from ROM.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid              : a, b, tw, scale_en, inverse valid this cycle
//   scale_en              : halve both outputs (rounded half-up)
//   inverse               : use conj(tw) for the IFFT
//   tw_re/tw_im           : negated twiddle, signed Q1.(TW-1)
//   a_re/a_im, b_re/b_im  : operands, signed DW bits
//   out_valid             : in_valid delayed MULT_LAT+1 cycles
//   outa_*/outb_*         : saturated results, held while out_valid=0
//   ovf / ovf_clr         : sticky saturation flag / clear (set wins)
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW       = FFT_DW,
    parameter int TW       = FFT_TW,
    parameter int MULT_LAT = FFT_MULT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 scale_en,
    input  logic                 inverse,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] outa_re,
    output logic signed [DW-1:0] outa_im,
    output logic signed [DW-1:0] outb_re,
    output logic signed [DW-1:0] outb_im,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int LANES = 4;
    localparam logic signed [TW-1:0] TW_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] TW_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [DW+1:0] ONE    = (DW+2)'(1);

    // Conjugate for the inverse transform; -(-1.0) clamps to the largest Q1 value.
    logic signed [TW-1:0] tw_im_next;
    always_comb begin
        tw_im_next = tw_im;
        if (inverse)
            tw_im_next = (tw_im == TW_MIN) ? TW_MAX : -tw_im;
    end

    logic signed [DW:0] p_re, p_im;

    cmplx_mult_pipe #(
        .DW       (DW),
        .TW       (TW),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .tw_re (tw_re),
        .tw_im (tw_im_next),
        .b_re  (b_re),
        .b_im  (b_im),
        .p_re  (p_re),
        .p_im  (p_im)
    );

    // Side band travelling with the product. Only the valid bits need reset:
    // data is never captured at the output without its valid.
    logic [MULT_LAT-1:0]  vld_sr_reg;
    logic [MULT_LAT-1:0]  scale_sr_reg;
    logic signed [DW-1:0] a_re_sr_reg [MULT_LAT];
    logic signed [DW-1:0] a_im_sr_reg [MULT_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_reg <= '0;
        end else begin
            vld_sr_reg[0] <= in_valid;
            for (int i = 1; i < MULT_LAT; i++)
                vld_sr_reg[i] <= vld_sr_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        scale_sr_reg[0] <= scale_en;
        a_re_sr_reg[0]  <= a_re;
        a_im_sr_reg[0]  <= a_im;
        for (int i = 1; i < MULT_LAT; i++) begin
            scale_sr_reg[i] <= scale_sr_reg[i-1];
            a_re_sr_reg[i]  <= a_re_sr_reg[i-1];
            a_im_sr_reg[i]  <= a_im_sr_reg[i-1];
        end
    end

    logic vld_m, scale_m;
    assign vld_m   = vld_sr_reg[MULT_LAT-1];
    assign scale_m = scale_sr_reg[MULT_LAT-1];

    // Lanes 0/1 produce outa (re/im), lanes 2/3 produce outb (re/im).
    logic signed [DW-1:0] lane_a  [LANES];
    logic signed [DW:0]   lane_p  [LANES];
    logic signed [DW+1:0] lane_sa [LANES];
    logic signed [DW+1:0] lane_r  [LANES];
    logic signed [DW-1:0] lane_q  [LANES];
    logic [LANES-1:0]     lane_clip;

    assign lane_a[0] = a_re_sr_reg[MULT_LAT-1];
    assign lane_a[1] = a_im_sr_reg[MULT_LAT-1];
    assign lane_a[2] = a_re_sr_reg[MULT_LAT-1];
    assign lane_a[3] = a_im_sr_reg[MULT_LAT-1];
    assign lane_p[0] = p_re;
    assign lane_p[1] = p_im;
    assign lane_p[2] = p_re;
    assign lane_p[3] = p_im;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < 2) begin : g_sub
                assign lane_sa[gi] = (DW+2)'(lane_a[gi]) - (DW+2)'(lane_p[gi]);
            end else begin : g_add
                assign lane_sa[gi] = (DW+2)'(lane_a[gi]) + (DW+2)'(lane_p[gi]);
            end
            assign lane_r[gi]    = scale_m ? ((lane_sa[gi] + ONE) >>> 1) : lane_sa[gi];
            assign lane_q[gi]    = DW'(sat(32'(lane_r[gi]), DW));
            assign lane_clip[gi] = sat_clip(32'(lane_r[gi]), DW);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            outa_re   <= '0;
            outa_im   <= '0;
            outb_re   <= '0;
            outb_im   <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= vld_m;
            if (vld_m) begin
                outa_re <= lane_q[0];
                outa_im <= lane_q[1];
                outb_re <= lane_q[2];
                outb_im <= lane_q[3];
            end
            if (vld_m && (|lane_clip))
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule
